// File: rtl/sprite_pkg.sv
// Shared types and widths for the sprite renderer and its animation sequencer.
package sprite_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } sprite_state_t;

  localparam int PIX_W    = 4;
  localparam int COORD_W  = 10;
  localparam int SCOORD_W = 11;

  // Counter width that stays legal (>= 1 bit) when the count is 1.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_anim_seq.sv
// Animation sequencer: steps through sprite frames every ANIM_DIV video frames,
// one-shot or looping, restartable at any time by anim_start.
module sprite_anim_seq
  import sprite_pkg::*;
#(
  parameter int FRAMES   = 4,
  parameter int ANIM_DIV = 8,
  localparam int FRAME_W = cnt_w(FRAMES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               anim_start,
  input  logic               anim_loop,
  output logic [FRAME_W-1:0] cur_frame,
  output logic               anim_done
);

  localparam int DIV_W = cnt_w(ANIM_DIV);
  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_PLAY = PLAY;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]       state;
  logic [DIV_W-1:0] div;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      div       <= '0;
      cur_frame <= '0;
    end else if (anim_start) begin
      state     <= S_PLAY;
      div       <= '0;
      cur_frame <= '0;
    end else if (state == S_PLAY && frame_tick) begin
      if (div == DIV_W'(ANIM_DIV - 1)) begin
        div <= '0;
        // anim_loop only matters at the wrap point; DONE keeps the last frame.
        if (cur_frame == FRAME_W'(FRAMES - 1)) begin
          if (anim_loop) cur_frame <= '0;
          else           state     <= S_DONE;
        end else begin
          cur_frame <= cur_frame + FRAME_W'(1);
        end
      end else begin
        div <= div + DIV_W'(1);
      end
    end
  end

  assign anim_done = (state == S_DONE);

endmodule

// File: rtl/sprite_animator.sv
// Multi-frame sprite renderer: beam position -> sprite ROM address -> keyed, registered RGB.
// Optional SPRITE_VFLIP_EN adds a flip_v input for vertical mirroring.
module sprite_animator
  import sprite_pkg::*;
#(
  parameter int SPR_W      = 30,
  parameter int SPR_H      = 30,
  parameter int FRAMES     = 4,
  parameter int IDX_W      = 3,
  parameter int ANIM_DIV   = 8,
  parameter int TRANSP_IDX = 0,
  localparam int ADDR_W    = $clog2(FRAMES * SPR_W * SPR_H),
  localparam int FRAME_W   = cnt_w(FRAMES)
) (
  input  logic               vga_clk,
  input  logic               reset_n,
  input  logic [COORD_W-1:0] pos_x,
  input  logic [COORD_W-1:0] pos_y,
  input  logic [COORD_W-1:0] draw_x,
  input  logic [COORD_W-1:0] draw_y,
  input  logic               blank,
  input  logic               frame_tick,
  input  logic               flip_h,
`ifdef SPRITE_VFLIP_EN
  input  logic               flip_v,
`endif
  input  logic               anim_start,
  input  logic               anim_loop,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [IDX_W-1:0]   rom_data,
  input  logic [PIX_W-1:0]   pal_red,
  input  logic [PIX_W-1:0]   pal_green,
  input  logic [PIX_W-1:0]   pal_blue,
  output logic [IDX_W-1:0]   pal_index,
  output logic [PIX_W-1:0]   red,
  output logic [PIX_W-1:0]   green,
  output logic [PIX_W-1:0]   blue,
  output logic               pixel_on,
  output logic               anim_done
);

  logic [COORD_W-1:0]  px, py;
  logic                fh;
  logic [FRAME_W-1:0]  cur_frame;
  logic [SCOORD_W-1:0] ox, oy, lx, ly, col, row;
  logic                in_box;
  logic [ADDR_W-1:0]   addr_next;
  logic                in_box_q1, blank_q1, in_box_q2, blank_q2;

  sprite_anim_seq #(
    .FRAMES   (FRAMES),
    .ANIM_DIV (ANIM_DIV)
  ) u_seq (
    .clk        (vga_clk),
    .rst_n      (reset_n),
    .frame_tick (frame_tick),
    .anim_start (anim_start),
    .anim_loop  (anim_loop),
    .cur_frame  (cur_frame),
    .anim_done  (anim_done)
  );

  // Shadows move only at vertical blank so a sprite never tears mid-frame.
`ifdef SPRITE_VFLIP_EN
  logic fv;
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n)        fv <= 1'b0;
    else if (frame_tick) fv <= flip_v;
  end
`endif

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      px <= '0;
      py <= '0;
      fh <= 1'b0;
    end else if (frame_tick) begin
      px <= pos_x;
      py <= pos_y;
      fh <= flip_h;
    end
  end

  // Signed 11-bit box arithmetic: a negative origin clips off the left/top edge.
  assign ox = {1'b0, px} - SCOORD_W'(SPR_W / 2);
  assign oy = {1'b0, py} - SCOORD_W'(SPR_H / 2);
  assign lx = {1'b0, draw_x} - ox;
  assign ly = {1'b0, draw_y} - oy;

  assign in_box = !lx[SCOORD_W-1] && (lx < SCOORD_W'(SPR_W)) &&
                  !ly[SCOORD_W-1] && (ly < SCOORD_W'(SPR_H));

  assign col = fh ? SCOORD_W'(SPR_W - 1) - lx : lx;
`ifdef SPRITE_VFLIP_EN
  assign row = fv ? SCOORD_W'(SPR_H - 1) - ly : ly;
`else
  assign row = ly;
`endif

  assign addr_next = ADDR_W'(cur_frame) * ADDR_W'(SPR_W * SPR_H)
                   + ADDR_W'(row) * ADDR_W'(SPR_W) + ADDR_W'(col);

  // NOTE: holding rom_addr outside the box is a clock-enabled flop, not a latch;
  // a missing else is only a latch hazard in combinational logic.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_addr  <= '0;
      in_box_q1 <= 1'b0;
      blank_q1  <= 1'b0;
      in_box_q2 <= 1'b0;
      blank_q2  <= 1'b0;
    end else begin
      if (in_box) rom_addr <= addr_next;
      in_box_q1 <= in_box;
      blank_q1  <= blank;
      in_box_q2 <= in_box_q1;
      blank_q2  <= blank_q1;
    end
  end

  assign pal_index = rom_data;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      red      <= '0;
      green    <= '0;
      blue     <= '0;
      pixel_on <= 1'b0;
    end else if (blank_q2 && in_box_q2 && rom_data != IDX_W'(TRANSP_IDX)) begin
      red      <= pal_red;
      green    <= pal_green;
      blue     <= pal_blue;
      pixel_on <= 1'b1;
    end else begin
      red      <= '0;
      green    <= '0;
      blue     <= '0;
      pixel_on <= 1'b0;
    end
  end

endmodule
